// File: rtl/vec_regfile_stream_if.sv
// Write channel of the streaming vector register file: one LANES-wide beat per handshake,
// plus the busy/done status that belongs to that channel.
interface vec_regfile_stream_if #(
    parameter int AW    = 5,
    parameter int ELEN  = 32,
    parameter int LANES = 8
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [AW-1:0]         wr_addr;
    logic [LANES*ELEN-1:0] wr_data;
    logic [LANES-1:0]      wr_mask;
    logic                  wr_busy;
    logic                  wr_done;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_mask,
        input  wr_ready, wr_busy, wr_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_mask,
        output wr_ready, wr_busy, wr_done
    );
endinterface

// File: rtl/vec_regfile_stream.sv
// Vector register file with combinational full-width reads and a multi-beat masked write port.
// Writes honour a per-beat vector length and lane mask; untouched elements keep their value.
module vec_regfile_stream #(
    parameter int NREG  = 32,
    parameter int ELEN  = 32,
    parameter int VLEN  = 64,
    parameter int LANES = 8,
    localparam int NBEATS = VLEN / LANES,
    localparam int AW     = $clog2(NREG),
    localparam int LW     = $clog2(VLEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [LW-1:0]        vl,
    vec_regfile_stream_if.slave  wr,
    input  logic [AW-1:0]        addr1,
    input  logic [AW-1:0]        addr2,
    output logic [VLEN*ELEN-1:0] v1,
    output logic [VLEN*ELEN-1:0] v2,
    output logic                 rd1_hazard,
    output logic                 rd2_hazard
);
    localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
    localparam logic [LW-1:0] VLEN_L    = LW'(VLEN);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t            state;
    state_t            state_next;
    logic [BW-1:0]     bcnt;
    logic [AW-1:0]     waddr;
    logic              done_q;
    logic [ELEN-1:0]   mem [NREG][NBEATS][LANES];

    logic              accept;
    logic              last_beat;
    logic [BW-1:0]     beat_sel;
    logic [AW-1:0]     addr_sel;
    logic [LW-1:0]     vl_eff;

    assign accept = wr.wr_valid && wr.wr_ready;

    // The first beat targets the incoming address; later beats reuse the latched one.
    always_comb begin
        beat_sel  = (state == IDLE) ? '0 : bcnt;
        addr_sel  = (state == IDLE) ? wr.wr_addr : waddr;
        vl_eff    = (vl > VLEN_L) ? VLEN_L : vl;
        last_beat = (state == IDLE) ? (NBEATS == 1) : (bcnt == LAST_BEAT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !last_beat) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (flush || (accept && last_beat)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr.wr_ready = !flush && !rst;
        wr.wr_busy  = (state == WRITE);
        wr.wr_done  = done_q;
        rd1_hazard  = (state == WRITE) && (addr1 == waddr);
        rd2_hazard  = (state == WRITE) && (addr2 == waddr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt   <= '0;
            waddr  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= accept && last_beat;
            if (flush) begin
                bcnt <= '0;
            end else if (accept) begin
                if (state == IDLE) begin
                    waddr <= wr.wr_addr;
                end
                bcnt <= last_beat ? '0 : beat_sel + BW'(1);
            end
        end
    end

    // Tail elements (index >= vl) and masked-off lanes are left undisturbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                for (int b = 0; b < NBEATS; b++) begin
                    for (int l = 0; l < LANES; l++) begin
                        mem[r][b][l] <= '0;
                    end
                end
            end
        end else if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr.wr_mask[l] && ((int'(beat_sel) * LANES + l) < int'(vl_eff))) begin
                    mem[addr_sel][beat_sel][l] <= wr.wr_data[l*ELEN +: ELEN];
                end
            end
        end
    end

    always_comb begin
        v1 = '0;
        v2 = '0;
        for (int b = 0; b < NBEATS; b++) begin
            for (int l = 0; l < LANES; l++) begin
                v1[(b*LANES+l)*ELEN +: ELEN] = mem[addr1][b][l];
                v2[(b*LANES+l)*ELEN +: ELEN] = mem[addr2][b][l];
            end
        end
    end
endmodule

// File: tb/tb_vec_regfile_stream.sv
// Directed bench for vec_regfile_stream: full writes, tail/mask, stall, flush,
// asynchronous reset mid-write and back-to-back writes.
module tb_vec_regfile_stream;
    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [6:0]   vl;
    logic [4:0]   addr1;
    logic [4:0]   addr2;
    logic [2047:0] v1;
    logic [2047:0] v2;
    logic         rd1_hazard;
    logic         rd2_hazard;

    int checks = 0;
    int errors = 0;

    vec_regfile_stream_if #(.AW(5), .ELEN(32), .LANES(8)) wr_if ();

    vec_regfile_stream #(.NREG(32), .ELEN(32), .VLEN(64), .LANES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .vl         (vl),
        .wr         (wr_if),
        .addr1      (addr1),
        .addr2      (addr2),
        .v1         (v1),
        .v2         (v2),
        .rd1_hazard (rd1_hazard),
        .rd2_hazard (rd2_hazard)
    );

    always #5 clk = ~clk;

    task automatic drive_beat(input logic [4:0] a, input logic [31:0] base, input bit inc,
                              input int b, input logic [7:0] m, input logic [6:0] v);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_mask  = m;
        vl             = v;
        for (int l = 0; l < 8; l++) begin
            wr_if.wr_data[l*32 +: 32] = inc ? base + 32'(b*8 + l) : base;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = '1;
        wr_if.wr_addr  = '0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] base, input bit inc,
                             input logic [7:0] m, input logic [6:0] v);
        for (int b = 0; b < 8; b++) begin
            drive_beat(a, base, inc, b, m, v);
            step();
        end
        go_idle();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        vl = 7'd64;
        addr1 = '0;
        addr2 = '0;
        wr_if.wr_mask = '0;
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_if.wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b expected 0", wr_if.wr_ready);
        end
        checks++;
        if (wr_if.wr_busy !== 1'b0 || wr_if.wr_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy_done: got %b/%b expected 0/0", wr_if.wr_busy, wr_if.wr_done);
        end
        checks++;
        if (v1 !== '0 || rd1_hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_read: v1 nonzero=%b hazard=%b expected 0/0", |v1, rd1_hazard);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (wr_if.wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_ready: got %b expected 1", wr_if.wr_ready);
        end
    endtask

    task automatic test_full_write();
        addr1 = 5'd5;
        for (int b = 0; b < 8; b++) begin
            drive_beat(5'd5, 32'd0, 1'b1, b, 8'hFF, 7'd64);
            step();
            checks++;
            if (wr_if.wr_busy !== (b < 7) || wr_if.wr_done !== (b == 7)) begin
                errors++;
                $display("[TB] FAIL full_status beat %0d: busy/done got %b/%b expected %b/%b",
                         b, wr_if.wr_busy, wr_if.wr_done, b < 7, b == 7);
            end
        end
        go_idle();
        step();
        checks++;
        if (wr_if.wr_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_done_pulse: got %b expected 0", wr_if.wr_done);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (v1[i*32 +: 32] !== 32'(i)) begin
                errors++;
                $display("[TB] FAIL full_data elem %0d: got %h expected %h", i, v1[i*32 +: 32], 32'(i));
            end
        end
    endtask

    task automatic test_tail_mask();
        logic [31:0] exp;
        addr1 = 5'd3;
        write_reg(5'd3, 32'hAAAA_AAAA, 1'b0, 8'hFF, 7'd100);
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (v1[i*32 +: 32] !== 32'hAAAA_AAAA) begin
                errors++;
                $display("[TB] FAIL vl_clamp elem %0d: got %h expected aaaaaaaa", i, v1[i*32 +: 32]);
            end
        end
        write_reg(5'd3, 32'h3000, 1'b1, 8'h0F, 7'd20);
        for (int i = 0; i < 64; i++) begin
            exp = (((i % 8) < 4) && (i < 20)) ? 32'h3000 + 32'(i) : 32'hAAAA_AAAA;
            checks++;
            if (v1[i*32 +: 32] !== exp) begin
                errors++;
                $display("[TB] FAIL tail_mask elem %0d: got %h expected %h", i, v1[i*32 +: 32], exp);
            end
        end
    endtask

    task automatic test_stall_hazard();
        addr1 = 5'd0;
        addr2 = 5'd7;
        #1;
        checks++;
        if (rd2_hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_hazard: got %b expected 0", rd2_hazard);
        end
        for (int b = 0; b < 3; b++) begin
            drive_beat(5'd7, 32'h7000, 1'b1, b, 8'hFF, 7'd64);
            step();
            checks++;
            if (rd2_hazard !== 1'b1 || rd1_hazard !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hazard beat %0d: rd2/rd1 got %b/%b expected 1/0", b, rd2_hazard, rd1_hazard);
            end
        end
        go_idle();
        for (int s = 0; s < 3; s++) begin
            step();
            checks++;
            if (rd2_hazard !== 1'b1 || wr_if.wr_busy !== 1'b1 || wr_if.wr_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold cycle %0d: hazard/busy/done got %b/%b/%b expected 1/1/0",
                         s, rd2_hazard, wr_if.wr_busy, wr_if.wr_done);
            end
        end
        for (int b = 3; b < 8; b++) begin
            drive_beat(5'd0, 32'h7000, 1'b1, b, 8'hFF, 7'd64);
            step();
            checks++;
            if (wr_if.wr_done !== (b == 7) || rd2_hazard !== (b < 7)) begin
                errors++;
                $display("[TB] FAIL stall_resume beat %0d: done/hazard got %b/%b expected %b/%b",
                         b, wr_if.wr_done, rd2_hazard, b == 7, b < 7);
            end
        end
        go_idle();
        step();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (v2[i*32 +: 32] !== 32'h7000 + 32'(i) || v1[i*32 +: 32] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL stall_data elem %0d: reg7 %h reg0 %h expected %h / 0",
                         i, v2[i*32 +: 32], v1[i*32 +: 32], 32'h7000 + 32'(i));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] exp;
        write_reg(5'd9, 32'h5555_5555, 1'b0, 8'hFF, 7'd64);
        for (int b = 0; b < 4; b++) begin
            drive_beat(5'd9, 32'h9000, 1'b1, b, 8'hFF, 7'd64);
            step();
        end
        drive_beat(5'd9, 32'h9000, 1'b1, 4, 8'hFF, 7'd64);
        flush = 1'b1;
        #1;
        checks++;
        if (wr_if.wr_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_ready: got %b expected 0", wr_if.wr_ready);
        end
        step();
        checks++;
        if (wr_if.wr_busy !== 1'b0 || wr_if.wr_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_state: busy/done got %b/%b expected 0/0", wr_if.wr_busy, wr_if.wr_done);
        end
        flush = 1'b0;
        for (int b = 0; b < 8; b++) begin
            drive_beat(5'd10, 32'hA000, 1'b1, b, 8'hFF, 7'd64);
            step();
            checks++;
            if (wr_if.wr_done !== (b == 7) || wr_if.wr_busy !== (b < 7)) begin
                errors++;
                $display("[TB] FAIL post_flush beat %0d: done/busy got %b/%b expected %b/%b",
                         b, wr_if.wr_done, wr_if.wr_busy, b == 7, b < 7);
            end
        end
        go_idle();
        addr1 = 5'd9;
        addr2 = 5'd10;
        step();
        for (int i = 0; i < 64; i++) begin
            exp = (i < 32) ? 32'h9000 + 32'(i) : 32'h5555_5555;
            checks++;
            if (v1[i*32 +: 32] !== exp || v2[i*32 +: 32] !== 32'hA000 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL flush_data elem %0d: reg9 %h reg10 %h expected %h / %h",
                         i, v1[i*32 +: 32], v2[i*32 +: 32], exp, 32'hA000 + 32'(i));
            end
        end
    endtask

    task automatic test_async_reset();
        addr1 = 5'd12;
        addr2 = 5'd5;
        for (int b = 0; b < 5; b++) begin
            drive_beat(5'd12, 32'hC000, 1'b1, b, 8'hFF, 7'd64);
            step();
        end
        drive_beat(5'd12, 32'hC000, 1'b1, 5, 8'hFF, 7'd64);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (wr_if.wr_ready !== 1'b0 || wr_if.wr_busy !== 1'b0 || wr_if.wr_done !== 1'b0 || rd1_hazard !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_rst_outputs: ready/busy/done/hazard got %b/%b/%b/%b expected 0/0/0/0",
                     wr_if.wr_ready, wr_if.wr_busy, wr_if.wr_done, rd1_hazard);
        end
        checks++;
        if (v1 !== '0 || v2 !== '0) begin
            errors++;
            $display("[TB] FAIL async_rst_array: v1 nonzero=%b v2 nonzero=%b expected 0/0", |v1, |v2);
        end
        drive_beat(5'd13, 32'hD000, 1'b1, 0, 8'hFF, 7'd64);
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (wr_if.wr_busy !== 1'b1 || wr_if.wr_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_rst_first: busy/done got %b/%b expected 1/0", wr_if.wr_busy, wr_if.wr_done);
        end
        for (int b = 1; b < 8; b++) begin
            drive_beat(5'd13, 32'hD000, 1'b1, b, 8'hFF, 7'd64);
            step();
            checks++;
            if (wr_if.wr_done !== (b == 7)) begin
                errors++;
                $display("[TB] FAIL post_rst_done beat %0d: got %b expected %b", b, wr_if.wr_done, b == 7);
            end
        end
        go_idle();
        addr1 = 5'd13;
        addr2 = 5'd12;
        step();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (v1[i*32 +: 32] !== 32'hD000 + 32'(i) || v2[i*32 +: 32] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL post_rst_data elem %0d: reg13 %h reg12 %h expected %h / 0",
                         i, v1[i*32 +: 32], v2[i*32 +: 32], 32'hD000 + 32'(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        addr1 = 5'd1;
        addr2 = 5'd2;
        for (int k = 0; k < 16; k++) begin
            if (k < 8) drive_beat(5'd1, 32'h1100, 1'b1, k, 8'hFF, 7'd64);
            else       drive_beat(5'd2, 32'h2200, 1'b1, k - 8, 8'hFF, 7'd64);
            step();
            checks++;
            if (wr_if.wr_done !== (k == 7 || k == 15) || wr_if.wr_busy !== (k != 7 && k != 15)) begin
                errors++;
                $display("[TB] FAIL b2b cycle %0d: done/busy got %b/%b expected %b/%b",
                         k, wr_if.wr_done, wr_if.wr_busy, k == 7 || k == 15, k != 7 && k != 15);
            end
        end
        go_idle();
        step();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (v1[i*32 +: 32] !== 32'h1100 + 32'(i) || v2[i*32 +: 32] !== 32'h2200 + 32'(i)) begin
                errors++;
                $display("[TB] FAIL b2b_data elem %0d: reg1 %h reg2 %h expected %h / %h",
                         i, v1[i*32 +: 32], v2[i*32 +: 32], 32'h1100 + 32'(i), 32'h2200 + 32'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_tail_mask();
        test_stall_hazard();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_regfile_stream.md
VEC_REGFILE_STREAM -- requirements
Module: vec_regfile_stream

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NREG, 32, number of vector registers.
- ELEN, 32, element width in bits.
- VLEN, 64, elements per register.
- LANES, 8, elements per write beat; VLEN % LANES == 0.
- Derived: NBEATS = VLEN/LANES; AW = clog2(NREG); LW = clog2(VLEN)+1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 flush  input  1  synchronous abort of an in-progress write.
REQ-005 vl  input  LW  active vector length; values > VLEN are treated as VLEN.
REQ-006 wr_valid  input  1  write beat valid.
REQ-007 wr_ready  output  1  write beat ready.
REQ-008 wr_addr  input  AW  destination register; sampled on the first beat only.
REQ-009 wr_data  input  LANES x ELEN  beat data, where lane l is element b*LANES+l.
REQ-010 wr_mask  input  LANES  per-lane write enable.
REQ-011 wr_busy  output  1  a multi-beat write is in progress.
REQ-012 wr_done  output  1  one-cycle pulse after the final beat commits.
REQ-013 addr1, addr2  input  AW  read addresses.
REQ-014 v1, v2  output  VLEN x ELEN  full-register read data.
REQ-015 rd1_hazard, rd2_hazard  output  1  the read address targets the register currently being written.

Function
REQ-016 Storage SHALL be NREG x VLEN x ELEN flops; there is no special-cased register.
REQ-017 v1/v2 SHALL be combinational reads of the array, with no write bypass; a beat committed at edge N is visible after edge N.
REQ-018 A beat is accepted when wr_valid && wr_ready; wr_ready = !flush (and 0 during rst).
REQ-019 FSM states: IDLE, WRITE; beat counter bcnt has width clog2(NBEATS), and at least 1 bit.
REQ-020 IDLE, beat accepted: latch wr_addr into waddr and commit beat 0.
- If NBEATS==1: stay in IDLE and pulse wr_done.
- Otherwise: bcnt<=1 and go to WRITE.
REQ-021 WRITE, beat accepted: commit beat bcnt to waddr (wr_addr ignored) and increment bcnt.
- When bcnt==NBEATS-1: go to IDLE, bcnt<=0, wr_done<=1 on the next cycle.
REQ-022 WRITE with no accepted beat: state and bcnt hold, with no timeout.
REQ-023 Element i=b*LANES+l SHALL be written iff wr_mask[l] && i < vl; all other elements are unchanged (tail/mask undisturbed).
REQ-024 vl is sampled per beat, not latched.
REQ-025 wr_busy = (state==WRITE).
REQ-026 rdN_hazard = wr_busy && (addrN == waddr), combinational.
REQ-027 flush high: go to IDLE, bcnt<=0, no wr_done. Beats already committed stay in the array, and a beat presented the same cycle is dropped.
REQ-028 wr_done SHALL be a registered pulse, high exactly one cycle per completed write, never on flush.
REQ-029 Back-to-back: a first beat of a new write MAY be accepted in the same cycle wr_done is high.

Reset
REQ-030 rst asserted: immediately (asynchronously) clear all array elements to 0, state=IDLE, bcnt=0, waddr=0, wr_done=0.
REQ-031 During rst: wr_ready=0, wr_busy=0, hazards=0; v1/v2 read 0.
REQ-032 rst mid-write SHALL abandon the write with no wr_done; the first edge after rst deasserts accepts a new first beat.

Verification (NREG=32, ELEN=32, VLEN=64, LANES=8, NBEATS=8)
REQ-033 Full write: rst, then 8 consecutive beats to reg 5 with data=idx, mask=FF, vl=64.
- Required: v1 (addr1=5) reads element i = i.
- Required: wr_done high exactly on the cycle after beat 7; wr_busy high for cycles 1..7.
REQ-034 Tail and mask: reg 3 preloaded with all 0xAAAA_AAAA, then written with vl=20, mask=0x0F on every beat.
- Required: only elements {0-3, 8-11, 16-19} change; all others stay 0xAAAA_AAAA.
REQ-035 Stall and hazard: write to reg 7 with wr_valid dropped for 3 cycles after beat 2, addr2=7.
- Required: rd2_hazard=1 throughout; bcnt holds at 3; completion still writes all 64 elements.
REQ-036 Flush: flush asserted on beat 4 of a write to reg 9.
- Required: elements 0-31 updated, 32-63 unchanged; no wr_done; next beat starts a new write at its own wr_addr.
REQ-037 Async reset mid-write: rst pulsed between edges at beat 5.
- Required: all outputs reset immediately, array reads 0, no wr_done; post-reset write completes normally.
REQ-038 Back-to-back: two 8-beat writes (regs 1 then 2) with wr_valid held high for 16 cycles.
- Required: two wr_done pulses 8 cycles apart; both registers hold correct data.
